// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: register index/data types,
// the result record carried through the load buffer, and default sizing.
package writeback_stage_pkg;

  typedef logic [4:0]  reg_index_t;
  typedef logic [31:0] reg_data_t;

  localparam reg_index_t REG_ZERO    = 5'd0;
  localparam int         WB_NUM_REGS = 32;

  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_SB_CNT_W   = 2;

  typedef struct packed {
    reg_index_t rd;
    reg_data_t  data;
  } wb_result_t;

endpackage

// File: rtl/writeback_stage_m_load_fifo.sv
// Load-result buffer for the writeback stage: DEPTH entries of wb_result_t,
// power-of-two depth so the read/write pointers wrap naturally.
module wb_load_fifo_m
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  wb_result_t push_data,
  input  logic       pop,
  output wb_result_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_result_t       mem_q [DEPTH];
  wb_result_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_stage_m.sv
// Writeback stage: arbitrates ALU results, buffered loads and direct loads onto the
// register-file write port. Pending-write scoreboard is built only with WB_SCOREBOARD_EN.
module writeback_stage_m
  import writeback_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int SB_CNT_W   = WB_SB_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  reg_index_t issue_rd,
  output logic       issue_ready,
  input  logic       alu_valid,
  input  reg_index_t alu_rd,
  input  reg_data_t  alu_data,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  reg_index_t ld_rd,
  input  reg_data_t  ld_data,
  output reg_index_t write_reg_addr,
  output reg_data_t  write_data,
  output logic       write_enable,
  input  reg_index_t query_addr_1,
  input  reg_index_t query_addr_2,
  output logic       busy_1,
  output logic       busy_2
);

  wb_result_t fifo_head;
  wb_result_t ld_result;
  wb_result_t win;
  logic       fifo_full, fifo_empty;
  logic       fifo_push, fifo_pop;
  logic       ld_acc, win_valid;

  logic       write_enable_q, write_enable_d;
  reg_index_t write_reg_addr_q, write_reg_addr_d;
  reg_data_t  write_data_q, write_data_d;

  // ld_ready comes from the registered FIFO count only, never from alu_valid.
  assign ld_ready       = !fifo_full;
  assign ld_acc         = ld_valid && ld_ready;
  assign ld_result.rd   = ld_rd;
  assign ld_result.data = ld_data;

  wb_load_fifo_m #(
    .DEPTH (FIFO_DEPTH)
  ) u_load_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (ld_result),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    fifo_pop  = 1'b0;
    fifo_push = ld_acc;
    if (alu_valid) begin
      win_valid = 1'b1;
      win.rd    = alu_rd;
      win.data  = alu_data;
    end else if (!fifo_empty) begin
      win_valid = 1'b1;
      win       = fifo_head;
      fifo_pop  = 1'b1;
    end else if (ld_acc) begin
      win_valid = 1'b1;
      win       = ld_result;
      fifo_push = 1'b0;
    end
  end

  // x0 results are consumed but never reach the register file.
  always_comb begin
    write_enable_d   = win_valid && (win.rd != REG_ZERO);
    write_reg_addr_d = write_reg_addr_q;
    write_data_d     = write_data_q;
    if (write_enable_d) begin
      write_reg_addr_d = win.rd;
      write_data_d     = win.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable_q   <= 1'b0;
      write_reg_addr_q <= REG_ZERO;
      write_data_q     <= '0;
    end else begin
      write_enable_q   <= write_enable_d;
      write_reg_addr_q <= write_reg_addr_d;
      write_data_q     <= write_data_d;
    end
  end

  assign write_enable   = write_enable_q;
  assign write_reg_addr = write_reg_addr_q;
  assign write_data     = write_data_q;

`ifdef WB_SCOREBOARD_EN
  localparam logic [SB_CNT_W-1:0] CNT_SAT = '1;

  logic [SB_CNT_W-1:0] cnt_q [WB_NUM_REGS];
  logic [SB_CNT_W-1:0] cnt_d [WB_NUM_REGS];
  logic                sb_inc, sb_dec, sb_same;

  assign issue_ready = (issue_rd == REG_ZERO) || (cnt_q[issue_rd] != CNT_SAT);
  assign busy_1      = (query_addr_1 != REG_ZERO) && (cnt_q[query_addr_1] != '0);
  assign busy_2      = (query_addr_2 != REG_ZERO) && (cnt_q[query_addr_2] != '0);

  assign sb_inc  = issue_valid && issue_ready && (issue_rd != REG_ZERO);
  assign sb_dec  = write_enable_d;
  assign sb_same = sb_inc && sb_dec && (issue_rd == win.rd);

  // Entry 0 is never touched, so x0 stays untracked.
  always_comb begin
    cnt_d = cnt_q;
    if (sb_inc && !sb_same) begin
      cnt_d[issue_rd] = cnt_q[issue_rd] + SB_CNT_W'(1);
    end
    if (sb_dec && !sb_same && (cnt_q[win.rd] != '0)) begin
      cnt_d[win.rd] = cnt_q[win.rd] - SB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < WB_NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A write retiring a register with no pending issue is an upstream protocol error.
  assert property (@(posedge clk) disable iff (reset)
    !(sb_dec && !sb_same && (cnt_q[win.rd] == '0)));
`else
  localparam int UNUSED_SB_CNT_W = SB_CNT_W;

  logic unused_sb_inputs;

  assign issue_ready      = 1'b1;
  assign busy_1           = 1'b0;
  assign busy_2           = 1'b0;
  assign unused_sb_inputs = ^{issue_valid, issue_rd, query_addr_1, query_addr_2};
`endif

endmodule

// File: tb/tb_writeback_stage_m.sv
// Self-checking bench for writeback_stage_m: directed scenarios plus randomized
// traffic against a queue-based reference model; adapts to WB_SCOREBOARD_EN.
module tb_writeback_stage_m;
  import writeback_stage_pkg::*;

  localparam int DEPTH = WB_FIFO_DEPTH;
  localparam int SAT   = (1 << WB_SB_CNT_W) - 1;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_ready;
  reg_index_t issue_rd;
  logic       alu_valid;
  reg_index_t alu_rd;
  reg_data_t  alu_data;
  logic       ld_valid, ld_ready;
  reg_index_t ld_rd;
  reg_data_t  ld_data;
  reg_index_t write_reg_addr;
  reg_data_t  write_data;
  logic       write_enable;
  reg_index_t query_addr_1, query_addr_2;
  logic       busy_1, busy_2;

  always #5 clk = ~clk;

  writeback_stage_m dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_ready    (issue_ready),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .write_reg_addr (write_reg_addr),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .query_addr_1   (query_addr_1),
    .query_addr_2   (query_addr_2),
    .busy_1         (busy_1),
    .busy_2         (busy_2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: load buffer as a queue, pending-write counts as plain ints.
  wb_result_t mq[$];
  int         sb[32];
  int         owed[32];
  bit         m_we;
  reg_index_t m_addr;
  reg_data_t  m_data;
  bit         ld_hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int r = 0; r < 32; r++) begin
      sb[r]   = 0;
      owed[r] = 0;
    end
    m_we    = 1'b0;
    m_addr  = REG_ZERO;
    m_data  = '0;
    ld_hold = 1'b0;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    if (!ld_hold) ld_valid = 1'b0;
  endtask

  task automatic set_alu(input reg_index_t rd, input reg_data_t d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
    if (rd != REG_ZERO) owed[rd]--;
  endtask

  task automatic set_ld(input reg_index_t rd, input reg_data_t d);
    ld_valid = 1'b1;
    ld_rd    = rd;
    ld_data  = d;
    ld_hold  = 1'b1;
    if (rd != REG_ZERO) owed[rd]--;
  endtask

  task automatic set_issue(input reg_index_t rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  // Inputs are driven at the falling edge; check, advance the model, cross one rising edge.
  task automatic step();
    bit         exp_ldr, exp_ir, acc, have_w;
    wb_result_t w;
    #1;
    exp_ldr = (mq.size() < DEPTH);
    exp_ir  = !SB_ON || (issue_rd == REG_ZERO) || (sb[issue_rd] < SAT);
    check_eq("write_enable", write_enable, m_we);
    if (m_we) begin
      check_eq("write_reg_addr", write_reg_addr, m_addr);
      check_eq("write_data", write_data, m_data);
    end
    check_eq("ld_ready", ld_ready, exp_ldr);
    check_eq("issue_ready", issue_ready, exp_ir);
    check_eq("busy_1", busy_1, SB_ON && (query_addr_1 != 0) && (sb[query_addr_1] > 0));
    check_eq("busy_2", busy_2, SB_ON && (query_addr_2 != 0) && (sb[query_addr_2] > 0));

    acc    = ld_valid && exp_ldr;
    have_w = 1'b0;
    w      = '0;
    if (acc) ld_hold = 1'b0;
    if (alu_valid) begin
      w = '{rd: alu_rd, data: alu_data};
      have_w = 1'b1;
    end else if (mq.size() > 0) begin
      w = mq.pop_front();
      have_w = 1'b1;
    end else if (acc) begin
      w = '{rd: ld_rd, data: ld_data};
      have_w = 1'b1;
      acc = 1'b0;
    end
    if (acc) mq.push_back('{rd: ld_rd, data: ld_data});
    if (issue_valid && exp_ir && issue_rd != 0) begin
      sb[issue_rd]++;
      owed[issue_rd]++;
    end
    m_we = have_w && (w.rd != 0);
    if (m_we) begin
      m_addr = w.rd;
      m_data = w.data;
      if (sb[w.rd] > 0) sb[w.rd]--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic reg_index_t pick_rd();
    reg_index_t r;
    r = reg_index_t'($urandom_range(0, 7));
    if (owed[r] <= 0) r = REG_ZERO;
    return r;
  endfunction

  initial begin
    int k;
    reset        = 1'b1;
    issue_valid  = 1'b0;
    issue_rd     = 5'd5;
    alu_valid    = 1'b0;
    alu_rd       = '0;
    alu_data     = '0;
    ld_valid     = 1'b0;
    ld_rd        = '0;
    ld_data      = '0;
    query_addr_1 = 5'd5;
    query_addr_2 = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_write_enable", write_enable, 0);
    check_eq("rst_write_reg_addr", write_reg_addr, 0);
    check_eq("rst_write_data", write_data, 0);
    check_eq("rst_ld_ready", ld_ready, 1);
    check_eq("rst_issue_ready", issue_ready, 1);
    check_eq("rst_busy_1", busy_1, 0);
    reset = 1'b0;

    // ALU only
    idle(); set_issue(5); step();
    idle(); set_alu(5, 32'hDEADBEEF); step();
    check_eq("t1_we", write_enable, 1);
    check_eq("t1_addr", write_reg_addr, 5);
    check_eq("t1_data", write_data, 32'hDEADBEEF);
    idle(); step();
    check_eq("t1_we_drop", write_enable, 0);

    // ALU/load collision
    idle(); set_issue(3); step();
    idle(); set_issue(4); step();
    idle(); set_alu(3, 32'h11); set_ld(4, 32'h22); step();
    check_eq("t2_first_addr", write_reg_addr, 3);
    check_eq("t2_first_data", write_data, 32'h11);
    idle(); step();
    check_eq("t2_second_addr", write_reg_addr, 4);
    check_eq("t2_second_data", write_data, 32'h22);
    idle(); step();

    // Backpressure: ALU busy for 4 cycles while three loads are offered
    for (int r = 10; r < 13; r++) begin
      idle(); set_issue(reg_index_t'(r)); step();
    end
    k = 0;
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i < 4) set_alu(0, reg_data_t'(i));
      if (!ld_hold && k < 3) begin
        set_ld(reg_index_t'(10 + k), 32'hA0 + reg_data_t'(k));
        k++;
      end
      if (i == 2) begin
        #1 check_eq("t3_ld_ready_low", ld_ready, 0);
      end
      step();
    end

    // Scoreboard saturation, same-cycle issue+write, drain
    query_addr_1 = 5'd7;
    query_addr_2 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(7); step();
    end
    idle(); set_issue(7);
    #1 check_eq("t4_issue_ready_sat", issue_ready, SB_ON ? 0 : 1);
    check_eq("t4_busy_7", busy_1, SB_ON ? 1 : 0);
    step();
    idle(); set_alu(7, 32'h7001); step();
    idle(); set_issue(7); set_alu(7, 32'h7002); step();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (owed[7] > 0) set_alu(7, 32'h7100 + reg_data_t'(i));
      step();
    end
    check_eq("t4_busy_clear", busy_1, 0);

    // x0
    query_addr_1 = 5'd0;
    query_addr_2 = 5'd0;
    idle(); set_alu(0, 32'h55); set_issue(0); step();
    check_eq("t5_we_x0", write_enable, 0);
    check_eq("t5_issue_ready_x0", issue_ready, 1);
    check_eq("t5_busy_x0", busy_2, 0);
    idle(); step();

    // Reset mid-flight: two buffered loads, r9 pending twice
    query_addr_1 = 5'd9;
    idle(); set_issue(9); step();
    idle(); set_issue(9); step();
    idle(); set_alu(0, 1); set_ld(9, 32'h901); step();
    idle(); set_alu(0, 2); set_ld(9, 32'h902); step();
    idle(); set_alu(0, 3); step();
    idle();
    #2 reset = 1'b1;
    #1;
    check_eq("t6_we", write_enable, 0);
    check_eq("t6_addr", write_reg_addr, 0);
    check_eq("t6_data", write_data, 0);
    check_eq("t6_ld_ready", ld_ready, 1);
    check_eq("t6_busy_1", busy_1, 0);
    check_eq("t6_issue_ready", issue_ready, 1);
    model_reset();
    ld_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(); step();
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      query_addr_1 = reg_index_t'($urandom_range(0, 7));
      query_addr_2 = reg_index_t'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 4) set_alu(pick_rd(), $urandom);
      if (!ld_hold && $urandom_range(0, 1) == 1) set_ld(pick_rd(), $urandom);
      if ($urandom_range(0, 1) == 1) set_issue(reg_index_t'($urandom_range(0, 7)));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      idle(); step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage_m.md
# writeback_stage_m

Writeback stage that drives the register file write port (`write_reg_addr`, `write_data`, `write_enable`).
- Merges single-cycle ALU results with variable-latency load results arriving over a valid/ready handshake.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between execute/memory and `register_file_m`.

## Interface
- `FIFO_DEPTH`, 2: load-result buffer entries (power of two, ≥2).
- `SB_CNT_W`, 2: width of each per-register pending-write counter.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  instruction with destination leaves decode this cycle.
- `issue_rd`  in  reg_index_t  its destination register.
- `issue_ready`  out  1  low when `issue_rd`'s counter is saturated; decode stalls.
- `alu_valid`  in  1  ALU result present; always accepted.
- `alu_rd`  in  reg_index_t  ALU destination.
- `alu_data`  in  reg_data_t  ALU result.
- `ld_valid`  in  1  load result present.
- `ld_ready`  out  1  load result accepted when `ld_valid && ld_ready`.
- `ld_rd`  in  reg_index_t  load destination.
- `ld_data`  in  reg_data_t  load result.
- `write_reg_addr`  out  reg_index_t  to register file.
- `write_data`  out  reg_data_t  to register file.
- `write_enable`  out  1  to register file.
- `query_addr_1`, `query_addr_2`  in  reg_index_t  rs1/rs2 being decoded.
- `busy_1`, `busy_2`  out  1  queried register has a pending write.

## Operation
**Arbitration** (each cycle, one winner loads the write-port register):
- ALU first, then FIFO head, then direct load.
- Direct load applies only when the FIFO is empty and `alu_valid` is low. Such a load bypasses the FIFO.
- Any accepted load that does not win is enqueued.
- The winner sets `write_enable=1`, `write_reg_addr=rd`, `write_data=data` for the next cycle.
- If no winner, `write_enable=0`; addr/data hold their previous values.

**Destination x0:**
- A result with rd=0 is consumed normally (dequeued or accepted).
- It produces `write_enable=0` and no scoreboard change.

**FIFO:**
- `ld_ready = (count < FIFO_DEPTH)`, taken from registered count only, with no combinational path from `alu_valid`.
- At full, a same-cycle dequeue does not raise `ld_ready` until the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`.

**Scoreboard:** one `SB_CNT_W`-bit counter per register 1–31; x0 is never tracked.
- Increment on `issue_valid && issue_ready && issue_rd!=0`.
- Decrement on the edge where a write with matching nonzero rd is loaded into the write-port register.
- Simultaneous increment and decrement of the same register leaves the counter unchanged.
- `issue_ready = !(counter[issue_rd] == 2^SB_CNT_W-1)`. `issue_ready` is always 1 for rd=0.
- `busy_n = (counter[query_addr_n] != 0)`, combinational from the counters. `busy_n` is 0 for x0.
- A decrement at 0 is a protocol error: the counter stays 0. An assertion flags it when `WB_SCOREBOARD_EN` is defined.

## Timing
**Reset** (asynchronous, any cycle, including mid-operation):
- FIFO emptied, counters cleared, write register cleared.
- `write_enable=0`, `write_reg_addr=0`, `write_data=0`.
- `ld_ready=1`, `busy_*=0`, `issue_ready=1`.
- Pending results are discarded.

**Latency:**
- ALU accepted in cycle N → `write_enable` in N+1.
- Direct load: N → N+1.
- Enqueued load: written at least 1 cycle after the first cycle with no `alu_valid`.

**Scoreboard timing:**
- `busy` drops in the same cycle `write_enable` is high. The register file's write bypass covers that read.
- Issue in cycle N → `busy` visible in N+1.

**Ordering:**
- Loads are written in acceptance order.
- ALU and load ordering is not preserved. The scoreboard counter makes this safe.

## Configuration
`WB_SCOREBOARD_EN`:
- **Defined:** scoreboard and its assertion are built as specified above.
- **Undefined:** counters are removed; `busy_1=busy_2=0` and `issue_ready=1` constantly. Hazards become decode's responsibility. Arbitration and FIFO are unchanged.

## Structure
**Shared package (system):**
- `wb_result_t` packed struct containing `reg_index_t rd` and `reg_data_t data`.
- Constants `WB_FIFO_DEPTH=2` and `WB_SB_CNT_W=2`.
- Reuse existing `reg_index_t`, `reg_data_t` and `REG_ZERO`.

**Sub-module `wb_load_fifo_m`:**
- Parameterized by depth, storing `wb_result_t`.
- Signals: push/pop, full/empty, head output.
- Asynchronous reset.

## Test plan
1. ALU only: `alu_valid`, rd=5, data=0xDEADBEEF in cycle 1 → cycle 2 `write_enable=1`, addr=5, data=0xDEADBEEF; cycle 3 `write_enable=0`.
2. Collision: ALU rd=3/0x11 and load rd=4/0x22 in cycle 1, then ALU idle → cycle 2 writes r3, cycle 3 writes r4.
3. Backpressure: `alu_valid` held 4 cycles while 3 loads are offered.
   - `ld_ready` falls after 2 loads are accepted.
   - The third load is held until the FIFO pops.
   - Loads are written in order after the ALU stops.
4. Scoreboard:
   - Issue rd=7 three times → `issue_ready=0` for rd=7 and `busy` for rd=7 is 1.
   - Three writes to r7 → busy clears only after the third.
   - Issue and write of r7 in the same cycle leaves the count unchanged.
5. x0: ALU rd=0 and issue rd=0 → `write_enable` stays 0, `busy` for x0 is 0, `issue_ready` is 1.
6. Reset mid-flight: FIFO holds 2 entries and the counter for r9 is 2; assert `reset` asynchronously → outputs go to reset values immediately and no write occurs after release.
